// File: rtl/fetch_seq_if.sv
// -----------------------------------------------------------------------------
// fetch_seq_if
// Instruction-memory fetch bus: req/gnt/rvalid handshake.
//   imem_req    : fetch request (master -> slave)
//   imem_addr   : fetch address (master -> slave)
//   imem_gnt    : request accepted this cycle (slave -> master)
//   imem_rvalid : read data valid (slave -> master)
//   imem_rdata  : instruction word (slave -> master)
// -----------------------------------------------------------------------------
interface fetch_seq_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_seq.sv
// -----------------------------------------------------------------------------
// fetch_seq
// Fetch sequencer for the single-stage core. Owns the architectural PC and
// walks each instruction through fetch (REQ/WAIT), execute (EXEC) and the
// next-PC update. Misaligned targets redirect to TRAP_PC; a fetch that gets
// no rvalid within MAX_WAIT cycles parks the sequencer in ERR (sticky).
//
// Ports:
//   clk           : system clock, rising edge
//   rst           : asynchronous reset, active low
//   imem          : instruction-memory bus (master side)
//   instr         : registered instruction word to the datapath
//   instr_valid   : one-cycle pulse, instr is new
//   ex_done       : execute finished; cond/imm/alu_out valid this cycle
//   cond          : 00 sequential, 01 jal/taken branch, 1x jalr
//   imm           : branch/jal offset
//   alu_out       : jalr target
//   pc            : current PC
//   misalign_trap : one-cycle pulse on trap redirect
//   epc           : PC of the instruction whose target faulted
//   bus_err       : sticky fetch-timeout flag
// -----------------------------------------------------------------------------
module fetch_seq #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_PC  = 32'h0000_0100,
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic               clk,
  input  logic               rst,
  fetch_seq_if.master        imem,
  output logic [31:0]        instr,
  output logic               instr_valid,
  input  logic               ex_done,
  input  logic [1:0]         cond,
  input  logic [31:0]        imm,
  input  logic [31:0]        alu_out,
  output logic [31:0]        pc,
  output logic               misalign_trap,
  output logic [31:0]        epc,
  output logic               bus_err
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    EXEC = 3'd3,
    ERR  = 3'd4
  } state_t;

  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] epc_q, epc_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        instr_valid_q, instr_valid_d;
  logic        trap_q, trap_d;
  logic [31:0] target;

  // Next-PC candidate; only consumed on ex_done in EXEC.
  always_comb begin
    target = pc_q + 32'd4;
    case (cond)
      2'b00:   target = pc_q + 32'd4;
      2'b01:   target = pc_q + imm;
      default: target = alu_out & 32'hFFFF_FFFE;  // jalr clears bit 0
    endcase
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    epc_d         = epc_q;
    wait_cnt_d    = wait_cnt_q;
    instr_valid_d = 1'b0;
    trap_d        = 1'b0;

    case (state_q)
      IDLE: begin
        // Late rvalid from an aborted fetch lands here and is dropped.
        state_d    = REQ;
        wait_cnt_d = 8'd0;
      end

      REQ: begin
        if (imem.imem_gnt) begin
          if (imem.imem_rvalid) begin
            instr_d       = imem.imem_rdata;
            instr_valid_d = 1'b1;
            state_d       = EXEC;
          end else begin
            state_d    = WAIT;
            wait_cnt_d = 8'd1;
          end
        end
      end

      WAIT: begin
        if (imem.imem_rvalid) begin
          instr_d       = imem.imem_rdata;
          instr_valid_d = 1'b1;
          state_d       = EXEC;
        end else if (wait_cnt_q >= MAX_WAIT_C) begin
          state_d = ERR;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end

      EXEC: begin
        if (ex_done) begin
          if (target[1:0] != 2'b00) begin
            pc_d   = TRAP_PC;
            epc_d  = pc_q;
            trap_d = 1'b1;
          end else begin
            pc_d = target;
          end
          state_d    = REQ;
          wait_cnt_d = 8'd0;
        end
      end

      ERR: begin
        state_d = ERR;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      instr_q       <= 32'd0;
      epc_q         <= 32'd0;
      wait_cnt_q    <= 8'd0;
      instr_valid_q <= 1'b0;
      trap_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      epc_q         <= epc_d;
      wait_cnt_q    <= wait_cnt_d;
      instr_valid_q <= instr_valid_d;
      trap_q        <= trap_d;
    end
  end

  assign imem.imem_req  = (state_q == REQ);
  assign imem.imem_addr = pc_q;
  assign instr          = instr_q;
  assign instr_valid    = instr_valid_q;
  assign pc             = pc_q;
  assign misalign_trap  = trap_q;
  assign epc            = epc_q;
  assign bus_err        = (state_q == ERR);

endmodule

// File: tb/tb_fetch_seq.sv
// -----------------------------------------------------------------------------
// tb_fetch_seq
// Directed bench for fetch_seq: zero-wait fetch, delayed grant/data, branch
// and jalr targets, PC wrap, misalign trap, fetch timeout and mid-execute
// reset. Inputs change 1 time unit after the rising edge; outputs are
// sampled at the same point.
// -----------------------------------------------------------------------------
module tb_fetch_seq;

  logic        clk;
  logic        rst;
  logic [31:0] instr;
  logic        instr_valid;
  logic        ex_done;
  logic [1:0]  cond;
  logic [31:0] imm;
  logic [31:0] alu_out;
  logic [31:0] pc;
  logic        misalign_trap;
  logic [31:0] epc;
  logic        bus_err;

  int n_asserts = 0;
  int n_fail    = 0;

  fetch_seq_if imem_bus ();

  fetch_seq #(
    .RESET_PC (32'h0000_0000),
    .TRAP_PC  (32'h0000_0100),
    .MAX_WAIT (16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .imem          (imem_bus.master),
    .instr         (instr),
    .instr_valid   (instr_valid),
    .ex_done       (ex_done),
    .cond          (cond),
    .imm           (imm),
    .alu_out       (alu_out),
    .pc            (pc),
    .misalign_trap (misalign_trap),
    .epc           (epc),
    .bus_err       (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One zero-wait fetch followed by ex_done in the first EXEC cycle.
  task automatic do_instr(input logic [31:0] exp_addr, input logic [31:0] data,
                          input logic [1:0] c, input logic [31:0] im,
                          input logic [31:0] alu, input logic exp_trap,
                          input logic [31:0] exp_next);
    chk("req_high", {31'd0, imem_bus.imem_req}, 32'd1);
    chk("fetch_addr", imem_bus.imem_addr, exp_addr);
    imem_bus.imem_gnt    = 1'b1;
    imem_bus.imem_rvalid = 1'b1;
    imem_bus.imem_rdata  = data;
    step();
    imem_bus.imem_gnt    = 1'b0;
    imem_bus.imem_rvalid = 1'b0;
    chk("ivalid_pulse", {31'd0, instr_valid}, 32'd1);
    chk("instr_word", instr, data);
    chk("req_low_exec", {31'd0, imem_bus.imem_req}, 32'd0);
    ex_done = 1'b1;
    cond    = c;
    imm     = im;
    alu_out = alu;
    step();
    ex_done = 1'b0;
    chk("ivalid_drop", {31'd0, instr_valid}, 32'd0);
    chk("trap_flag", {31'd0, misalign_trap}, {31'd0, exp_trap});
    chk("next_pc", pc, exp_next);
    $display("instr pc=%h data=%h cond=%b -> pc=%h trap=%0b", exp_addr, data, c, pc, misalign_trap);
  endtask

  initial begin
    rst                  = 1'b0;
    ex_done              = 1'b0;
    cond                 = 2'b00;
    imm                  = 32'd0;
    alu_out              = 32'd0;
    imem_bus.imem_gnt    = 1'b0;
    imem_bus.imem_rvalid = 1'b0;
    imem_bus.imem_rdata  = 32'd0;

    // Reset state
    step();
    step();
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_epc", epc, 32'h0);
    chk("rst_ivalid", {31'd0, instr_valid}, 32'd0);
    chk("rst_trap", {31'd0, misalign_trap}, 32'd0);
    chk("rst_buserr", {31'd0, bus_err}, 32'd0);
    chk("rst_req", {31'd0, imem_bus.imem_req}, 32'd0);
    $display("reset: pc=%h req=%0b", pc, imem_bus.imem_req);

    // Release: one IDLE cycle, then REQ
    rst = 1'b1;
    chk("idle_req", {31'd0, imem_bus.imem_req}, 32'd0);
    step();

    // Zero-wait sequential fetches 0,4,8,C then branch back from 0x10
    do_instr(32'h0, 32'hA000_0000, 2'b00, 32'h0, 32'h0, 1'b0, 32'h4);
    do_instr(32'h4, 32'hA000_0004, 2'b00, 32'h0, 32'h0, 1'b0, 32'h8);
    do_instr(32'h8, 32'hA000_0008, 2'b00, 32'h0, 32'h0, 1'b0, 32'hC);
    do_instr(32'hC, 32'hA000_000C, 2'b00, 32'h0, 32'h0, 1'b0, 32'h10);
    do_instr(32'h10, 32'hB000_0010, 2'b01, 32'hFFFF_FFF8, 32'h0, 1'b0, 32'h8);

    // Delayed grant: stray ex_done and rvalid in REQ are ignored
    ex_done              = 1'b1;
    cond                 = 2'b01;
    imm                  = 32'h40;
    imem_bus.imem_rvalid = 1'b1;
    step();
    ex_done              = 1'b0;
    imem_bus.imem_rvalid = 1'b0;
    chk("hold_req1", {31'd0, imem_bus.imem_req}, 32'd1);
    chk("hold_addr1", imem_bus.imem_addr, 32'h8);
    chk("hold_ivalid", {31'd0, instr_valid}, 32'd0);
    step();
    chk("hold_addr2", imem_bus.imem_addr, 32'h8);
    step();
    chk("hold_addr3", imem_bus.imem_addr, 32'h8);
    chk("hold_req3", {31'd0, imem_bus.imem_req}, 32'd1);
    imem_bus.imem_gnt = 1'b1;
    step();
    imem_bus.imem_gnt = 1'b0;
    chk("wait_req_low", {31'd0, imem_bus.imem_req}, 32'd0);
    chk("wait_ivalid0", {31'd0, instr_valid}, 32'd0);
    step();
    chk("wait_ivalid1", {31'd0, instr_valid}, 32'd0);
    imem_bus.imem_rvalid = 1'b1;
    imem_bus.imem_rdata  = 32'hC0DE_0008;
    step();
    imem_bus.imem_rvalid = 1'b0;
    chk("slow_ivalid", {31'd0, instr_valid}, 32'd1);
    chk("slow_instr", instr, 32'hC0DE_0008);
    step();
    chk("slow_ivalid_once", {31'd0, instr_valid}, 32'd0);
    chk("exec_hold_pc", pc, 32'h8);
    $display("slow fetch: instr=%h pc=%h", instr, pc);

    // jalr to 0xFFFF_FFFD -> 0xFFFF_FFFC, then sequential wrap to 0
    ex_done = 1'b1;
    cond    = 2'b10;
    alu_out = 32'hFFFF_FFFD;
    step();
    ex_done = 1'b0;
    chk("jalr_hi_pc", pc, 32'hFFFF_FFFC);
    chk("jalr_hi_trap", {31'd0, misalign_trap}, 32'd0);
    do_instr(32'hFFFF_FFFC, 32'h1111_1111, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0);

    // To 0x20, jalr 0x105 -> 0x104, back to 0x20, jalr 0x106 -> trap
    do_instr(32'h0, 32'h2222_2222, 2'b01, 32'h20, 32'h0, 1'b0, 32'h20);
    do_instr(32'h20, 32'h3333_3333, 2'b10, 32'h0, 32'h105, 1'b0, 32'h104);
    do_instr(32'h104, 32'h4444_4444, 2'b01, 32'hFFFF_FF1C, 32'h0, 1'b0, 32'h20);
    do_instr(32'h20, 32'h5555_5555, 2'b11, 32'h0, 32'h106, 1'b1, 32'h100);
    chk("trap_epc", epc, 32'h20);
    step();
    chk("trap_one_pulse", {31'd0, misalign_trap}, 32'd0);
    chk("trap_addr", imem_bus.imem_addr, 32'h100);

    // Timeout: grant, then no rvalid for MAX_WAIT cycles
    imem_bus.imem_gnt = 1'b1;
    step();
    imem_bus.imem_gnt = 1'b0;
    chk("to_req_low", {31'd0, imem_bus.imem_req}, 32'd0);
    repeat (15) step();
    chk("to_not_yet", {31'd0, bus_err}, 32'd0);
    step();
    chk("to_bus_err", {31'd0, bus_err}, 32'd1);
    $display("timeout: bus_err=%0b pc=%h", bus_err, pc);
    imem_bus.imem_gnt    = 1'b1;
    imem_bus.imem_rvalid = 1'b1;
    ex_done              = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("err_no_req", {31'd0, imem_bus.imem_req}, 32'd0);
      chk("err_pc_frozen", pc, 32'h100);
      chk("err_sticky", {31'd0, bus_err}, 32'd1);
    end
    imem_bus.imem_gnt    = 1'b0;
    imem_bus.imem_rvalid = 1'b0;
    ex_done              = 1'b0;
    rst = 1'b0;
    #1;
    chk("err_rst_clear", {31'd0, bus_err}, 32'd0);
    chk("err_rst_pc", pc, 32'h0);
    chk("err_rst_epc", epc, 32'h0);
    step();
    rst = 1'b1;
    chk("err_idle_req", {31'd0, imem_bus.imem_req}, 32'd0);
    step();
    chk("restart_req", {31'd0, imem_bus.imem_req}, 32'd1);
    chk("restart_addr", imem_bus.imem_addr, 32'h0);
    $display("restart after error: addr=%h", imem_bus.imem_addr);

    // Reset mid-EXEC with ex_done held
    imem_bus.imem_gnt    = 1'b1;
    imem_bus.imem_rvalid = 1'b1;
    imem_bus.imem_rdata  = 32'h7777_7777;
    step();
    imem_bus.imem_gnt    = 1'b0;
    imem_bus.imem_rvalid = 1'b0;
    chk("mid_ivalid", {31'd0, instr_valid}, 32'd1);
    ex_done = 1'b1;
    cond    = 2'b01;
    imm     = 32'h40;
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_pc", pc, 32'h0);
    chk("mid_rst_ivalid", {31'd0, instr_valid}, 32'd0);
    chk("mid_rst_instr", instr, 32'h0);
    step();
    chk("mid_rst_hold_pc", pc, 32'h0);
    rst                  = 1'b1;
    imem_bus.imem_rvalid = 1'b1;
    chk("late_idle_req", {31'd0, imem_bus.imem_req}, 32'd0);
    step();
    imem_bus.imem_rvalid = 1'b0;
    chk("post_rst_req", {31'd0, imem_bus.imem_req}, 32'd1);
    chk("post_rst_addr", imem_bus.imem_addr, 32'h0);
    chk("post_rst_ivalid", {31'd0, instr_valid}, 32'd0);
    chk("post_rst_pc", pc, 32'h0);
    ex_done = 1'b0;
    $display("mid-exec reset: addr=%h", imem_bus.imem_addr);
    do_instr(32'h0, 32'h8888_8888, 2'b00, 32'h0, 32'h0, 1'b0, 32'h4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
